cmd_uart_rx: RTL and testbench

Serial command front-end for the tamagotchi core. Receives 8N1 UART bytes from the host terminal, keeps only recognised command characters, and presents each one on an 8-bit command bus for a fixed hold window before returning the bus to 0x00. The stats block re-arms only when its command input returns to 0x00, so each keypress is applied exactly once. This block drives the stats block's `inputs` port.

---
 rtl/tama_pkg.sv | 36 +++
 rtl/uart_rx_core.sv | 109 ++++++++++
 rtl/cmd_uart_rx.sv | 90 +++++++++
 tb/tb_cmd_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// Shared constants, receiver state encoding and command-filter helpers.
package tama_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_EAT   = 8'h65;
    localparam logic [BYTE_W-1:0] CMD_PLAY  = 8'h70;
    localparam logic [BYTE_W-1:0] CMD_DOC   = 8'h64;
    localparam logic [BYTE_W-1:0] CMD_BATH  = 8'h62;
    localparam logic [BYTE_W-1:0] CMD_SLEEP = 8'h73;
    localparam logic [BYTE_W-1:0] CMD_WAKE  = 8'h77;
    localparam logic [BYTE_W-1:0] CMD_NONE  = 8'h00;

    typedef enum logic [2:0] {
        RX_ARM,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Fold 'A'..'Z' onto 'a'..'z'; everything else passes unchanged.
    function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b);
        if (b >= 8'h41 && b <= 8'h5A) begin
            return b | 8'h20;
        end
        return b;
    endfunction

    // True for the six command characters the stats block understands.
    function automatic logic is_cmd(input logic [BYTE_W-1:0] b);
        return (b == CMD_EAT)   || (b == CMD_PLAY) || (b == CMD_DOC) ||
               (b == CMD_BATH)  || (b == CMD_SLEEP) || (b == CMD_WAKE);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, framing FSM, baud/bit counters.
// byte_valid_c/byte_data_c flag a good stop sample in the same cycle so the
// parent can load its command register on the same edge as rx_strobe.
module uart_rx_core
    import tama_pkg::*;
#(
    parameter int unsigned DIV  = 234,
    parameter int unsigned HALF = 117
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_strobe,
    output logic              frame_err,
    output logic              byte_valid_c,
    output logic [BYTE_W-1:0] byte_data_c
);

    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic [1:0]        sync_q;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] rx_byte_q;
    logic              rx_strobe_q;
    logic              frame_err_q;
    logic              rxs;

    assign rxs = sync_q[1];

    // Good stop bit sampled this cycle.
    assign byte_valid_c = (state_q == RX_STOP) && (cnt_q == DIV_LAST) && rxs;
    assign byte_data_c  = shift_q;

    assign rx_byte   = rx_byte_q;
    assign rx_strobe = rx_strobe_q;
    assign frame_err = frame_err_q;

    // Synchroniser, receiver FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= RX_ARM;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx};
            rx_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                RX_ARM: begin
                    if (rxs) state_q <= RX_IDLE;
                end
                RX_IDLE: begin
                    if (!rxs) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[BYTE_W-1:1]};
                        bit_q   <= bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(7)) state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            rx_byte_q   <= shift_q;
                            rx_strobe_q <= 1'b1;
                            state_q     <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= RX_ARM;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_ARM;
            endcase
        end
    end

endmodule

// File: rtl/cmd_uart_rx.sv
// Serial command front-end: filters received bytes to command characters and
// holds each on cmd for HOLD_CYCLES, with a one-cycle 0x00 gap on replacement.
module cmd_uart_rx
    import tama_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned HOLD_CYCLES = 270000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [BYTE_W-1:0] cmd,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_strobe,
    output logic              frame_err
);

    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned HALF   = DIV / 2;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    logic              byte_valid_c;
    logic [BYTE_W-1:0] byte_data_c;
    logic [BYTE_W-1:0] folded_c;
    logic              accept_c;

    logic [BYTE_W-1:0] cmd_q;
    logic [HOLD_W-1:0] hold_q;
    logic [BYTE_W-1:0] pend_q;
    logic              pend_v_q;

    uart_rx_core #(
        .DIV  (DIV),
        .HALF (HALF)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_byte      (rx_byte),
        .rx_strobe    (rx_strobe),
        .frame_err    (frame_err),
        .byte_valid_c (byte_valid_c),
        .byte_data_c  (byte_data_c)
    );

    // Case-fold and match against the command set.
    always_comb begin
        folded_c = fold_case(byte_data_c);
        accept_c = byte_valid_c && is_cmd(folded_c);
    end

    assign cmd = cmd_q;

    // Command hold window, pending slot and countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= CMD_NONE;
            hold_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else if (accept_c) begin
            if (cmd_q == CMD_NONE) begin
                // Idle bus (or the gap cycle): newest byte loads directly.
                cmd_q    <= folded_c;
                hold_q   <= HOLD_LOAD;
                pend_v_q <= 1'b0;
            end else begin
                // Drop the bus for one cycle so the stats block re-arms.
                pend_q   <= folded_c;
                pend_v_q <= 1'b1;
                cmd_q    <= CMD_NONE;
                hold_q   <= '0;
            end
        end else if (pend_v_q && cmd_q == CMD_NONE) begin
            cmd_q    <= pend_q;
            hold_q   <= HOLD_LOAD;
            pend_v_q <= 1'b0;
        end else if (cmd_q != CMD_NONE) begin
            if (hold_q == HOLD_W'(1)) begin
                cmd_q  <= CMD_NONE;
                hold_q <= '0;
            end else begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_uart_rx.sv
// Directed bench for cmd_uart_rx at a reduced clock/baud/hold scale.
module tb_cmd_uart_rx;

    localparam int unsigned CLK_HZ = 3300;
    localparam int unsigned BAUD   = 100;
    localparam int unsigned DIV    = 33;
    localparam int unsigned HOLD   = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] cmd;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       frame_err;

    cmd_uart_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .cmd       (cmd),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_cmd;
    } vec_t;

    typedef struct {
        logic [7:0] v;
        int         n;
    } run_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_strobe = 0;
    int   n_ferr   = 0;
    logic [7:0] last_rx       = 8'h00;
    logic [7:0] cmd_at_strobe = 8'h00;
    logic [7:0] cmd_at_ferr   = 8'h00;
    logic [7:0] prev_cmd      = 8'h00;
    int   run_n = 0;
    run_t runs[$];

    // Output observer: strobe/error counts and run lengths of each cmd value.
    always @(negedge clk) begin
        if (rx_strobe === 1'b1) begin
            n_strobe++;
            last_rx       = rx_byte;
            cmd_at_strobe = cmd;
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            cmd_at_ferr = cmd;
        end
        if (cmd !== prev_cmd) begin
            runs.push_back('{v: prev_cmd, n: run_n});
            prev_cmd = cmd;
            run_n    = 1;
        end else begin
            run_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(posedge clk);
        end
        rx = stop;
        repeat (DIV) @(posedge clk);
        if (stop) begin
            repeat (DIV) @(posedge clk);
        end
    endtask

    task automatic wait_cmd(input logic [7:0] v, input int budget, input string name);
        int k = 0;
        while (cmd !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(cmd), 32'(v));
    endtask

    task automatic check_last_run(input logic [7:0] v, input string name);
        repeat (2) @(negedge clk);
        if (runs.size() == 0) begin
            chk({name, "_present"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_val"}, 32'(runs[runs.size()-1].v), 32'(v));
            chk({name, "_len"}, 32'(runs[runs.size()-1].n), 32'(HOLD));
        end
    endtask

    vec_t vecs[14];

    initial begin
        int s0;
        int f0;

        vecs[0]  = '{8'h65, 8'h65};  // 'e'
        vecs[1]  = '{8'h50, 8'h70};  // 'P' folds to 'p'
        vecs[2]  = '{8'h78, 8'h00};  // 'x' rejected
        vecs[3]  = '{8'h42, 8'h62};  // 'B'
        vecs[4]  = '{8'h53, 8'h73};  // 'S'
        vecs[5]  = '{8'h57, 8'h77};  // 'W'
        vecs[6]  = '{8'h44, 8'h64};  // 'D'
        vecs[7]  = '{8'h45, 8'h65};  // 'E'
        vecs[8]  = '{8'h61, 8'h00};  // 'a'
        vecs[9]  = '{8'h40, 8'h00};  // '@' just below 'A'
        vecs[10] = '{8'h5B, 8'h00};  // '[' just above 'Z'
        vecs[11] = '{8'h5A, 8'h00};  // 'Z' folds to 'z', not a command
        vecs[12] = '{8'h70, 8'h00 | 8'h70};  // 'p'
        vecs[13] = '{8'hE5, 8'h00};  // high bit set, no fold

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'h00);
        chk("rst_rx_byte", 32'(rx_byte), 32'h00);
        chk("rst_strobe", 32'(rx_strobe), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        // Table of single frames.
        for (int i = 0; i < 14; i++) begin
            s0 = n_strobe;
            send_byte(vecs[i].tx, 1'b1);
            chk($sformatf("v%0d_strobes", i), 32'(n_strobe - s0), 32'd1);
            chk($sformatf("v%0d_rx_byte", i), 32'(last_rx), 32'(vecs[i].tx));
            chk($sformatf("v%0d_cmd", i), 32'(cmd_at_strobe), 32'(vecs[i].exp_cmd));
            if (vecs[i].exp_cmd != 8'h00) begin
                wait_cmd(8'h00, HOLD + 20, $sformatf("v%0d_release", i));
                check_last_run(vecs[i].exp_cmd, $sformatf("v%0d_hold", i));
            end
            repeat (5) @(posedge clk);
        end

        // Replacement during a hold: 'd' then 's'.
        runs.delete();
        send_byte(8'h64, 1'b1);
        wait_cmd(8'h64, 50, "pend_first");
        repeat (20) @(posedge clk);
        send_byte(8'h73, 1'b1);
        wait_cmd(8'h73, 50, "pend_second");
        wait_cmd(8'h00, HOLD + 20, "pend_release");
        repeat (2) @(negedge clk);
        chk("pend_runs", 32'(runs.size()), 32'd4);
        if (runs.size() == 4) begin
            chk("pend_run1_val", 32'(runs[1].v), 32'h64);
            chk("pend_gap_val", 32'(runs[2].v), 32'h00);
            chk("pend_gap_len", 32'(runs[2].n), 32'd1);
            chk("pend_run3_val", 32'(runs[3].v), 32'h73);
            chk("pend_run3_len", 32'(runs[3].n), 32'(HOLD));
        end

        // Short low glitch is ignored; the next frame still lands.
        s0 = n_strobe;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (8) @(posedge clk);
        rx = 1'b1;
        repeat (100) @(posedge clk);
        chk("glitch_strobes", 32'(n_strobe - s0), 32'd0);
        chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);
        send_byte(8'h70, 1'b1);
        chk("glitch_next_cmd", 32'(cmd_at_strobe), 32'h70);
        wait_cmd(8'h00, HOLD + 20, "glitch_release");

        // Framing error followed by a break; no frames until the line rises.
        s0 = n_strobe;
        f0 = n_ferr;
        send_byte(8'h65, 1'b0);
        repeat (5000) @(posedge clk);
        chk("ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("ferr_strobes", 32'(n_strobe - s0), 32'd0);
        chk("ferr_cmd", 32'(cmd_at_ferr), 32'h00);
        chk("ferr_cmd_after", 32'(cmd), 32'h00);
        rx = 1'b1;
        repeat (50) @(posedge clk);
        s0 = n_strobe;
        send_byte(8'h77, 1'b1);
        chk("ferr_w_strobes", 32'(n_strobe - s0), 32'd1);
        chk("ferr_w_cmd", 32'(cmd_at_strobe), 32'h77);
        wait_cmd(8'h00, HOLD + 20, "ferr_w_release");

        // Reset during data bit 4 of 0xF0 (line high from bit 4 on).
        s0 = n_strobe;
        f0 = n_ferr;
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (175) @(posedge clk);
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("rstf_cmd", 32'(cmd), 32'h00);
                chk("rstf_rx_byte", 32'(rx_byte), 32'h00);
                chk("rstf_strobe", 32'(rx_strobe), 32'h0);
                chk("rstf_ferr", 32'(frame_err), 32'h0);
                reset = 1'b0;
            end
        join
        repeat (50) @(posedge clk);
        chk("rstf_no_strobe", 32'(n_strobe - s0), 32'd0);
        chk("rstf_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Reset during a hold.
        send_byte(8'h62, 1'b1);
        wait_cmd(8'h62, 50, "rsth_load");
        repeat (10) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rsth_cmd", 32'(cmd), 32'h00);
        chk("rsth_rx_byte", 32'(rx_byte), 32'h00);
        reset = 1'b0;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        chk("rsth_cmd_stays", 32'(cmd), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
